// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD host sequencer: state encoding, default
// data width and the result value returned on a rejected request.
package gcd_pkg;

    localparam int GCD_WIDTH = 16;

    localparam logic [GCD_WIDTH-1:0] ZERO_RESULT = '0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_SEND_A = 3'd2,
        ST_SEND_B = 3'd3,
        ST_WAIT   = 3'd4,
        ST_GAP    = 3'd5,
        ST_RESP   = 3'd6
    } seq_state_e;

endpackage

// File: rtl/gcd_seq_counter.sv
// Loadable down-counter shared by the GAP hold-off and the WAIT watchdog.
// Holds at zero; load takes priority over decrement.
module gcd_seq_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/gcd_host_seq.sv
// Host-side sequencer for the serial GCD engine: request -> start/A/B on the
// shared bus -> wait done -> response. Define GCD_SEQ_TIMEOUT_EN for the watchdog.
module gcd_host_seq
    import gcd_pkg::*;
#(
    parameter int WIDTH   = GCD_WIDTH,
    parameter int TIMEOUT = 1024,
    parameter int GAP     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             eng_start,
    output logic [WIDTH-1:0] eng_data,
    input  logic             eng_done,
    input  logic [WIDTH-1:0] eng_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_error,
    output logic             busy
);

    localparam int CNT_MAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_error_q, rsp_error_d;
    logic             req_ready_q, req_ready_d;
    logic             eng_start_q, eng_start_d;
    logic [WIDTH-1:0] eng_data_q, eng_data_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;

    logic             cnt_load;
    logic [CW-1:0]    cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;

    gcd_seq_counter #(.CW(CW)) u_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_result_d = rsp_result_q;
        rsp_error_d  = rsp_error_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    // A zero operand never reaches the engine
                    if ((req_a == '0) || (req_b == '0)) begin
                        rsp_result_d = WIDTH'(ZERO_RESULT);
                        rsp_error_d  = 1'b1;
                        state_d      = ST_RESP;
                    end else begin
                        a_d     = req_a;
                        b_d     = req_b;
                        state_d = ST_START;
                    end
                end
            end
            ST_START:  state_d = ST_SEND_A;
            ST_SEND_A: state_d = ST_SEND_B;
            ST_SEND_B: begin
                state_d = ST_WAIT;
`ifdef GCD_SEQ_TIMEOUT_EN
                cnt_load     = 1'b1;
                cnt_load_val = CW'(TIMEOUT - 1);
`endif
            end
            ST_WAIT: begin
                if (eng_done) begin
                    rsp_result_d = eng_result;
                    rsp_error_d  = 1'b0;
                    state_d      = ST_GAP;
                    cnt_load     = 1'b1;
                    cnt_load_val = CW'(GAP - 1);
`ifdef GCD_SEQ_TIMEOUT_EN
                end else if (cnt_zero) begin
                    rsp_result_d = WIDTH'(ZERO_RESULT);
                    rsp_error_d  = 1'b1;
                    state_d      = ST_GAP;
                    cnt_load     = 1'b1;
                    cnt_load_val = CW'(GAP - 1);
                end else begin
                    cnt_dec = 1'b1;
`endif
                end
            end
            ST_GAP: begin
                if (cnt_zero) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they appear registered
        req_ready_d = (state_d == ST_IDLE);
        eng_start_d = (state_d == ST_START) || (state_d == ST_SEND_A) ||
                      (state_d == ST_SEND_B) || (state_d == ST_WAIT);
        case (state_d)
            ST_SEND_A:         eng_data_d = a_d;
            ST_SEND_B, ST_WAIT: eng_data_d = b_d;
            default:           eng_data_d = '0;
        endcase
        rsp_valid_d = (state_d == ST_RESP);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b0;
            req_ready_q  <= 1'b1;
            eng_start_q  <= 1'b0;
            eng_data_q   <= '0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_result_q <= rsp_result_d;
            rsp_error_q  <= rsp_error_d;
            req_ready_q  <= req_ready_d;
            eng_start_q  <= eng_start_d;
            eng_data_q   <= eng_data_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign eng_start  = eng_start_q;
    assign eng_data   = eng_data_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_error  = rsp_error_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_gcd_host_seq.sv
// Bench for gcd_host_seq: engine responder, transaction-level timing model,
// per-cycle compare process and directed + random host traffic.
module tb_gcd_host_seq;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 16;
    localparam int GAP     = 2;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             eng_start;
    logic [WIDTH-1:0] eng_data;
    logic             eng_done;
    logic [WIDTH-1:0] eng_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_error;
    logic             busy;

    gcd_host_seq #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .eng_start  (eng_start),
        .eng_data   (eng_data),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_error  (rsp_error),
        .busy       (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [WIDTH:0] exp_q[$];

    function automatic logic [WIDTH-1:0] ref_gcd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int unsigned x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x[WIDTH-1:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
        end
    endtask

    task automatic note_timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected event at t=%0t", name, $time);
    endtask

    // ---------------- transaction-level model ----------------
    int               edge_n;
    int               m_acc;
    int               m_done;
    int               m_rsp_at;
    bit               m_busy;
    bit               m_zero;
    logic [WIDTH-1:0] m_a;
    logic [WIDTH-1:0] m_b;

    initial begin
        edge_n = 0; m_busy = 0; m_zero = 0; m_acc = 0; m_done = -1; m_rsp_at = -1;
        m_a = '0; m_b = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                edge_n = 0; m_busy = 0; m_done = -1; m_rsp_at = -1;
                exp_q.delete();
            end else begin
                edge_n++;
                if (!m_busy) begin
                    if (req_valid) begin
                        m_busy = 1; m_acc = edge_n; m_a = req_a; m_b = req_b; m_done = -1;
                        m_zero = (req_a == '0) || (req_b == '0);
                        if (m_zero) begin
                            m_rsp_at = edge_n;
                            exp_q.push_back({1'b1, {WIDTH{1'b0}}});
                        end else begin
                            m_rsp_at = -1;
                            exp_q.push_back({1'b0, ref_gcd(req_a, req_b)});
                        end
                    end
                end else if (m_rsp_at >= 0) begin
                    if ((edge_n > m_rsp_at) && rsp_ready) begin
                        m_busy = 0;
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                    end
                end else begin
                    if (eng_done && (edge_n >= m_acc + 4)) begin
                        m_done = edge_n; m_rsp_at = edge_n + GAP;
                    end
`ifdef GCD_SEQ_TIMEOUT_EN
                    else if (edge_n == m_acc + 3 + TIMEOUT) begin
                        m_done = edge_n; m_rsp_at = edge_n + GAP;
                        if (exp_q.size() > 0) exp_q[0] = {1'b1, {WIDTH{1'b0}}};
                    end
`endif
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        bit               e_rv, e_start;
        int               k;
        logic [WIDTH-1:0] e_data;
        forever begin
            @(negedge clk);
            if (!rst) begin
                e_rv    = m_busy && (m_rsp_at >= 0) && (edge_n >= m_rsp_at);
                e_start = m_busy && !m_zero && ((m_done < 0) || (edge_n < m_done));
                k       = edge_n - m_acc;
                e_data  = !e_start ? '0 : (k == 0) ? '0 : (k == 1) ? m_a : m_b;
                check("req_ready", req_ready, !m_busy);
                check("busy", busy, m_busy);
                check("eng_start", eng_start, e_start);
                check("eng_data", eng_data, e_data);
                check("rsp_valid", rsp_valid, e_rv);
                if (e_rv) begin
                    if (exp_q.size() == 0) note_timeout("rsp_expected_entry");
                    else check("rsp_payload", {rsp_error, rsp_result}, exp_q[0]);
                end
            end
        end
    end

    // ---------------- engine responder ----------------
    int               phase;
    int               lat;
    bit               never_done;
    logic [WIDTH-1:0] ea, eb;

    initial begin
        eng_done = 1'b0; eng_result = '0; phase = 0; lat = 1; ea = '0; eb = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                phase = 0; eng_done = 1'b0;
            end else if (!eng_start) begin
                phase = 0;
                eng_done   = ($urandom_range(0, 5) == 0);
                eng_result = WIDTH'($urandom);
            end else begin
                phase++;
                if (phase == 1) lat = $urandom_range(1, 6);
                if (phase == 2) ea = eng_data;
                if (phase == 3) eb = eng_data;
                if (phase <= 3) begin
                    eng_done   = ($urandom_range(0, 3) == 0);
                    eng_result = WIDTH'($urandom);
                end else if (!never_done && (phase == 3 + lat)) begin
                    eng_done   = 1'b1;
                    eng_result = ref_gcd(ea, eb);
                end else begin
                    eng_done   = 1'b0;
                    eng_result = WIDTH'($urandom);
                end
            end
        end
    end

    // ---------------- host driver tasks ----------------
    bit rsp_tied;

    task automatic send_req(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int n = 0;
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) note_timeout("req_ready_wait");
        req_valid = 1'b1; req_a = a; req_b = b;
        @(negedge clk);
        req_valid = 1'b0; req_a = WIDTH'($urandom); req_b = WIDTH'($urandom);
    endtask

    task automatic wait_rsp(input int hold, output logic [WIDTH-1:0] res, output logic err);
        int n = 0;
        while (!rsp_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) note_timeout("rsp_valid_wait");
        res = rsp_result;
        err = rsp_error;
        repeat (hold) @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = rsp_tied;
    endtask

    // ---------------- main sequence ----------------
    logic [WIDTH-1:0] res, ra, rb;
    logic             err;

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0;
        rsp_ready = 1'b0; rsp_tied = 0; never_done = 0;
        #2 rst = 1'b1;
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_eng_start", eng_start, 0);
        check("rst_eng_data", eng_data, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_error", rsp_error, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        send_req(16'd48, 16'd18);
        wait_rsp(0, res, err);
        check("gcd_48_18_result", res, 6);
        check("gcd_48_18_error", err, 0);

        send_req(16'd0, 16'd35);
        wait_rsp(0, res, err);
        check("zero_op_result", res, 0);
        check("zero_op_error", err, 1);

        send_req(16'd256, 16'd192);
        req_valid = 1'b1; req_a = 16'd9; req_b = 16'd6;
        wait_rsp(10, res, err);
        check("hold_256_192_result", res, 64);
        check("hold_256_192_error", err, 0);

        rsp_tied = 1; rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ra = WIDTH'($urandom_range(1, 256));
            rb = WIDTH'($urandom_range(1, 256));
            send_req(ra, rb);
            wait_rsp(0, res, err);
            check("b2b_result", res, ref_gcd(ra, rb));
        end
        rsp_tied = 0; rsp_ready = 1'b0;

        send_req(16'd100, 16'd75);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_req_ready", req_ready, 1);
        check("abort_eng_start", eng_start, 0);
        check("abort_eng_data", eng_data, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_rsp_result", rsp_result, 0);
        check("abort_rsp_error", rsp_error, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_req(16'd21, 16'd14);
        wait_rsp(0, res, err);
        check("after_abort_result", res, 7);

`ifdef GCD_SEQ_TIMEOUT_EN
        never_done = 1;
        send_req(16'd30, 16'd12);
        wait_rsp(0, res, err);
        check("timeout_result", res, 0);
        check("timeout_error", err, 1);
        never_done = 0;
`endif

        for (int i = 0; i < 8; i++) begin
            ra = ($urandom_range(0, 4) == 0) ? '0 : WIDTH'($urandom_range(1, 1000));
            rb = WIDTH'($urandom_range(1, 1000));
            send_req(ra, rb);
            wait_rsp($urandom_range(0, 3), res, err);
            check("rand_result", res, (ra == '0) ? '0 : ref_gcd(ra, rb));
            check("rand_error", err, (ra == '0) ? 1 : 0);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        note_timeout("global_watchdog");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
